hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised hazard unit for the 5-stage pipelined ARM core, successor to the fixed single-purpose stall/forward logic.
- Produces forwarding selects, stall and flush controls, and adds a multi-cycle execute (MUL) hold counter.
- Provides saturating stall/flush performance counters.
- Sits between controller and datapath; all pipeline-register enables and clears come from here.

Parameters:
- REG_ADDR_W, 4, register address width; address all-ones (R15) is never forwarded.
- MUL_LAT, 4, cycles a multiply occupies Execute (≥1; 1 means no hold).
- CNT_W, 32, width of performance counters.
- FWD_EN, 1, 1 enables forwarding; 0 makes every RAW hazard on E sources a stall.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- RA1D, RA2D  in  REG_ADDR_W  source registers in Decode
- RA1E, RA2E  in  REG_ADDR_W  source registers in Execute
- WA3E, WA3M, WA3W  in  REG_ADDR_W  destination registers in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write valid
- MemtoRegE  in  1  instruction in E is a load
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC-writing instruction in stage
- BranchTakenE  in  1  branch resolved taken in E
- MulStartE  in  1  multi-cycle op entered E this cycle
- ClearCnt  in  1  synchronous clear of performance counters
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  bubble into stage register
- MulBusy  out  1  multiply holding E
- MulDoneE  out  1  one-cycle pulse on final multiply cycle
- StallCnt, FlushCnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: mul counter 0, MulBusy=0, MulDoneE=0, StallCnt=FlushCnt=0. Combinational outputs follow their inputs.
- Forwarding (FWD_EN=1): ForwardAE=10 if RA1E==WA3M & RegWriteM & RA1E!=all-ones; else 01 if RA1E==WA3W & RegWriteW & not all-ones; else 00. M has priority over W. ForwardBE is the same using RA2E.
- FWD_EN=0: Forward*=00. RawStall = (RA1D or RA2D matches WA3E/WA3M/WA3W with the corresponding RegWrite set).
- LDRstall = (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE.
- PCWrPending = PCSrcD|PCSrcE|PCSrcM.
- Mul counter states:
  - IDLE (cnt=0). On MulStartE & !BranchTakenE & MUL_LAT>1, load cnt=MUL_LAT-1 → BUSY.
  - BUSY (cnt≠0): decrement each cycle; MulBusy=1.
  - MulDoneE=1 in the cycle cnt==1, or in the start cycle when MUL_LAT==1.
  - MulStartE while BUSY is ignored.
- Stall/flush equations:
  - StallF = LDRstall|RawStall|PCWrPending|MulBusy.
  - StallD = LDRstall|RawStall|MulBusy.
  - StallE = MulBusy.
  - FlushD = (PCWrPending|PCSrcW|BranchTakenE) & !MulBusy.
  - FlushE = (LDRstall|RawStall|BranchTakenE) & !MulBusy.
  - FlushM = MulBusy.
  - MulBusy dominates: E holds, and bubbles go into M, not E.
- Counters:
  - StallCnt += 1 each cycle StallD=1.
  - FlushCnt += 1 each cycle FlushD|FlushE=1.
  - Both saturate at all-ones.
  - ClearCnt has priority over increment (counters go to 0 that cycle).
- Reset mid-multiply aborts immediately: MulBusy=0 asynchronously.

Test Plan:
- Forward from M: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. With RA1E=WA3M=15 → ForwardAE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1 for one cycle, StallCnt=1.
- Branch: BranchTakenE=1 → FlushD=FlushE=1, StallF=0. PCSrcD=1 alone → StallF=1, FlushD=1.
- Multiply (MUL_LAT=4): MulStartE pulse → MulBusy=1, StallE=1 and FlushM=1 for the next 3 cycles; MulDoneE high in the 3rd. A second MulStartE during busy is ignored.
- Counters: force StallD for 2^CNT_W+2 cycles (CNT_W=4) → StallCnt holds 15. ClearCnt with StallD=1 → 0.
- Reset asserted mid-multiply (cnt=2) → MulBusy=0 and counters 0 without a clock edge. After release, a fresh MulStartE restarts the full latency.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding selects, stall/flush controls, a multi-cycle
// execute hold for multiplies, and saturating stall/flush event counters.
module hazard_unit_mc #(
  parameter int REG_ADDR_W = 4,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 32,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] RA1E,
  input  logic [REG_ADDR_W-1:0] RA2E,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic [REG_ADDR_W-1:0] WA3M,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  PCSrcM,
  input  logic                  PCSrcW,
  input  logic                  BranchTakenE,
  input  logic                  MulStartE,
  input  logic                  ClearCnt,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  MulBusy,
  output logic                  MulDoneE,
  output logic [CNT_W-1:0]      StallCnt,
  output logic [CNT_W-1:0]      FlushCnt
);

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = '1;
  localparam int                    MC_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0]       MC_LOAD = MC_W'(MUL_LAT - 1);

  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

  mul_state_t       r_state, w_state_next;
  logic [MC_W-1:0]  r_mul_cnt, w_mul_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_ldr_stall, w_raw_hit, w_raw_stall, w_pc_wr_pending, w_mul_start;

  // R15 holds the PC, which is never produced by the ALU, so it is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (FWD_EN != 0) begin
      if (RegWriteM && (RA1E == WA3M) && (RA1E != PC_ADDR))      ForwardAE = 2'b10;
      else if (RegWriteW && (RA1E == WA3W) && (RA1E != PC_ADDR)) ForwardAE = 2'b01;
      if (RegWriteM && (RA2E == WA3M) && (RA2E != PC_ADDR))      ForwardBE = 2'b10;
      else if (RegWriteW && (RA2E == WA3W) && (RA2E != PC_ADDR)) ForwardBE = 2'b01;
    end
  end

  assign w_raw_hit = (RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E))) ||
                     (RegWriteM && ((RA1D == WA3M) || (RA2D == WA3M))) ||
                     (RegWriteW && ((RA1D == WA3W) || (RA2D == WA3W)));
  assign w_raw_stall     = (FWD_EN == 0) && w_raw_hit;
  assign w_ldr_stall     = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE && RegWriteE;
  assign w_pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;
  assign w_mul_start     = MulStartE && !BranchTakenE && (r_state == MUL_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= MUL_IDLE;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mul_cnt <= w_mul_cnt_next;
    end
  end

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_mul_cnt_next = r_mul_cnt;
    case (r_state)
      MUL_IDLE: begin
        if (w_mul_start && (MUL_LAT > 1)) begin
          w_state_next   = MUL_BUSY;
          w_mul_cnt_next = MC_LOAD;
        end
      end
      MUL_BUSY: begin
        w_mul_cnt_next = r_mul_cnt - MC_W'(1);
        if (r_mul_cnt == MC_W'(1)) w_state_next = MUL_IDLE;
      end
      default: begin
        w_state_next   = MUL_IDLE;
        w_mul_cnt_next = '0;
      end
    endcase
  end

  assign MulBusy  = (r_state == MUL_BUSY);
  assign MulDoneE = (MulBusy && (r_mul_cnt == MC_W'(1))) ||
                    ((MUL_LAT == 1) && w_mul_start);

  // A held Execute stage cannot take a bubble, so bubbles go into Memory instead.
  assign StallF = w_ldr_stall || w_raw_stall || w_pc_wr_pending || MulBusy;
  assign StallD = w_ldr_stall || w_raw_stall || MulBusy;
  assign StallE = MulBusy;
  assign FlushD = (w_pc_wr_pending || PCSrcW || BranchTakenE) && !MulBusy;
  assign FlushE = (w_ldr_stall || w_raw_stall || BranchTakenE) && !MulBusy;
  assign FlushM = MulBusy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (ClearCnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != '1))              r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((FlushD || FlushE) && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a forwarding and a non-forwarding instance share
// stimulus and are compared each cycle against a cycle-indexed reference model.
module tb_hazard_unit_mc;

  localparam int AW  = 4;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, ClearCnt;

  logic [1:0]    fae [2];
  logic [1:0]    fbe [2];
  logic          sf [2], sd [2], se [2], fd [2], fe [2], fm [2], busy [2], done [2];
  logic [CW-1:0] scnt_o [2];
  logic [CW-1:0] fcnt_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: cycle index, last busy cycle of the current multiply, counters.
  int cyc     = 0;
  int mul_end = -1;
  int m_scnt [2];
  int m_fcnt [2];
  bit e_sd [2];
  bit e_fl [2];

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_ADDR_W(AW), .MUL_LAT(LAT), .CNT_W(CW), .FWD_EN(1)) dut_fwd (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .ClearCnt(ClearCnt),
    .ForwardAE(fae[0]), .ForwardBE(fbe[0]),
    .StallF(sf[0]), .StallD(sd[0]), .StallE(se[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]),
    .MulBusy(busy[0]), .MulDoneE(done[0]),
    .StallCnt(scnt_o[0]), .FlushCnt(fcnt_o[0])
  );

  hazard_unit_mc #(.REG_ADDR_W(AW), .MUL_LAT(LAT), .CNT_W(CW), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE), .ClearCnt(ClearCnt),
    .ForwardAE(fae[1]), .ForwardBE(fbe[1]),
    .StallF(sf[1]), .StallD(sd[1]), .StallE(se[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]),
    .MulBusy(busy[1]), .MulDoneE(done[1]),
    .StallCnt(scnt_o[1]), .FlushCnt(fcnt_o[1])
  );

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[inst%0d] cyc=%0d observed=%0h expected=%0h", tag, idx, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input bit en, input logic [AW-1:0] ra);
    if (!en || ra == 4'hF) return 2'b00;
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all();
    bit en, b, ldr, raw, pcw, x_sf, x_sd, x_fd, x_fe, x_done;
    #1;
    b   = (cyc <= mul_end);
    ldr = (RA1D == WA3E || RA2D == WA3E) && MemtoRegE && RegWriteE;
    pcw = PCSrcD || PCSrcE || PCSrcM;
    for (int i = 0; i < 2; i++) begin
      en  = (i == 0);
      raw = !en && ((RegWriteE && (RA1D == WA3E || RA2D == WA3E)) ||
                    (RegWriteM && (RA1D == WA3M || RA2D == WA3M)) ||
                    (RegWriteW && (RA1D == WA3W || RA2D == WA3W)));
      x_sf   = ldr || raw || pcw || b;
      x_sd   = ldr || raw || b;
      x_fd   = (pcw || PCSrcW || BranchTakenE) && !b;
      x_fe   = (ldr || raw || BranchTakenE) && !b;
      x_done = (b && cyc == mul_end) || (LAT == 1 && MulStartE && !BranchTakenE && !b);
      check("ForwardAE", i, 32'(fae[i]), 32'(exp_fwd(en, RA1E)));
      check("ForwardBE", i, 32'(fbe[i]), 32'(exp_fwd(en, RA2E)));
      check("StallF",    i, 32'(sf[i]),  32'(x_sf));
      check("StallD",    i, 32'(sd[i]),  32'(x_sd));
      check("StallE",    i, 32'(se[i]),  32'(b));
      check("FlushD",    i, 32'(fd[i]),  32'(x_fd));
      check("FlushE",    i, 32'(fe[i]),  32'(x_fe));
      check("FlushM",    i, 32'(fm[i]),  32'(b));
      check("MulBusy",   i, 32'(busy[i]), 32'(b));
      check("MulDoneE",  i, 32'(done[i]), 32'(x_done));
      check("StallCnt",  i, 32'(scnt_o[i]), 32'(m_scnt[i]));
      check("FlushCnt",  i, 32'(fcnt_o[i]), 32'(m_fcnt[i]));
      e_sd[i] = x_sd;
      e_fl[i] = x_fd || x_fe;
    end
  endtask

  task automatic model_reset();
    mul_end = -1;
    for (int i = 0; i < 2; i++) begin
      m_scnt[i] = 0;
      m_fcnt[i] = 0;
    end
  endtask

  task automatic advance();
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ClearCnt) begin
          m_scnt[i] = 0;
          m_fcnt[i] = 0;
        end else begin
          if (e_sd[i] && m_scnt[i] < CMAX) m_scnt[i]++;
          if (e_fl[i] && m_fcnt[i] < CMAX) m_fcnt[i]++;
        end
      end
      if (!(cyc <= mul_end) && MulStartE && !BranchTakenE && LAT > 1)
        mul_end = cyc + LAT - 1;
    end
    cyc++;
  endtask

  // Check the current cycle, commit the model across the edge, park at the next negedge.
  task automatic step();
    check_all();
    advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, ClearCnt} = '0;
  endtask

  function automatic logic [AW-1:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    step();
    reset = 1'b0;
    step();

    // Forwarding from M beats W; R15 is never forwarded.
    RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    step();
    #1 check("fwd_m_prio", 0, 32'(fae[0]), 32'd2);
    RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15;
    step();
    #1 check("fwd_r15", 0, 32'(fae[0]), 32'd0);
    RA2E = 4'd6; WA3M = 4'd2; WA3W = 4'd6;
    step();
    clear_inputs();
    step();

    // Load-use stall for one cycle.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    step();
    clear_inputs();
    #1 check("ldr_cnt", 0, 32'(scnt_o[0]), 32'd1);
    step();

    // Branch taken, then a PC write in Decode alone.
    BranchTakenE = 1'b1;
    step();
    BranchTakenE = 1'b0; PCSrcD = 1'b1;
    step();
    PCSrcD = 1'b0; PCSrcW = 1'b1;
    step();
    clear_inputs();

    // Multiply with a second start while busy.
    MulStartE = 1'b1;
    step();
    step();
    MulStartE = 1'b0;
    repeat (2) step();
    #1 check("mul_ignore_restart", 0, 32'(busy[0]), 32'd0);
    step();

    // Reset in the middle of a multiply, with nonzero counters.
    PCSrcD = 1'b1; MulStartE = 1'b1;
    step();
    PCSrcD = 1'b0; MulStartE = 1'b0;
    step();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_async_busy", i, 32'(busy[i]), 32'd0);
      check("rst_async_scnt", i, 32'(scnt_o[i]), 32'd0);
      check("rst_async_fcnt", i, 32'(fcnt_o[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // A fresh multiply after reset occupies the full latency.
    MulStartE = 1'b1;
    step();
    MulStartE = 1'b0;
    n_busy = 0;
    for (int k = 0; k < LAT; k++) begin
      if (busy[0] === 1'b1) n_busy++;
      step();
    end
    check("mul_full_latency", 0, 32'(n_busy), 32'(LAT - 1));

    // Saturate the stall counter, then clear it while still stalling.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    repeat ((1 << CW) + 2) step();
    #1 check("stall_sat", 0, 32'(scnt_o[0]), 32'(CMAX));
    ClearCnt = 1'b1;
    step();
    ClearCnt = 1'b0;
    #1 check("clear_prio", 0, 32'(scnt_o[0]), 32'd0);
    clear_inputs();
    step();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      RA1D = rand_reg(); RA2D = rand_reg(); RA1E = rand_reg(); RA2E = rand_reg();
      WA3E = rand_reg(); WA3M = rand_reg(); WA3W = rand_reg();
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MulStartE = ($urandom_range(0, 5) == 0);
      ClearCnt = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
